ac97_frame_out: RTL and testbench



---
 rtl/ac97_pkg.sv | 40 ++++
 rtl/ac97_bitclk_sync.sv | 22 ++
 rtl/ac97_frame_out.sv | 120 ++++++++++++
 tb/tb_ac97_frame_out.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - AC97 frame constants, tag bit indices and output-frame builder
package ac97_pkg;

    localparam int C_SLOT_BITS  = 20;
    localparam int C_TAG_BITS   = 16;
    localparam int C_FRAME_BITS = 256;
    localparam int C_SYNC_BITS  = 16;

    localparam int TAG_VALID    = 15;
    localparam int TAG_CMD_ADDR = 14;
    localparam int TAG_CMD_DATA = 13;
    localparam int TAG_PCM_L    = 12;
    localparam int TAG_PCM_R    = 11;

    // Slot 0 tag, slots 1-4, then eight always-zero slots; reads carry no slot 2 data.
    function automatic logic [C_FRAME_BITS-1:0] build_frame(
        input logic                   pcm_take,
        input logic [C_SLOT_BITS-1:0] pcm_l,
        input logic [C_SLOT_BITS-1:0] pcm_r,
        input logic                   cmd_take,
        input logic                   cmd_rd,
        input logic [6:0]             cmd_addr,
        input logic [15:0]            cmd_data
    );
        logic [C_TAG_BITS-1:0]  tag;
        logic [C_SLOT_BITS-1:0] s1, s2, s3, s4;
        tag               = '0;
        tag[TAG_VALID]    = pcm_take | cmd_take;
        tag[TAG_CMD_ADDR] = cmd_take;
        tag[TAG_CMD_DATA] = cmd_take & ~cmd_rd;
        tag[TAG_PCM_L]    = pcm_take;
        tag[TAG_PCM_R]    = pcm_take;
        s1 = cmd_take ? {cmd_rd, cmd_addr, 12'h000} : '0;
        s2 = (cmd_take && !cmd_rd) ? {cmd_data, 4'h0} : '0;
        s3 = pcm_take ? pcm_l : '0;
        s4 = pcm_take ? pcm_r : '0;
        return {tag, s1, s2, s3, s4, {(8*C_SLOT_BITS){1'b0}}};
    endfunction

endpackage

// File: rtl/ac97_bitclk_sync.sv
// rtl/ac97_bitclk_sync.sv - BIT_CLK two-flop synchroniser and rising-edge tick generator
module ac97_bitclk_sync (
    input  logic Sys_clk,
    input  logic Ac97_rst_n,
    input  logic Ac97_bitclk,
    output logic Bit_tick
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Left unreset so they keep tracking BIT_CLK through a reset and never fake an edge on release.
    always_ff @(posedge Sys_clk) begin
        meta_q <= Ac97_bitclk;
        sync_q <= meta_q;
        prev_q <= sync_q;
    end

    assign Bit_tick = sync_q & ~prev_q & Ac97_rst_n;

endmodule

// File: rtl/ac97_frame_out.sv
// rtl/ac97_frame_out.sv - AC97 output frame serialiser (PCM slots 3/4, command slots 1/2 when AC97_CMD_EN)
module ac97_frame_out #(
    parameter int C_PCM_WIDTH = 32,
    parameter int C_SLOT_BITS = 20
) (
    input  logic                   Sys_clk,
    input  logic                   Ac97_rst_n,
    input  logic                   Ac97_bitclk,
    input  logic [C_PCM_WIDTH-1:0] Pcm_l,
    input  logic [C_PCM_WIDTH-1:0] Pcm_r,
    input  logic                   Pcm_valid,
    output logic                   Pcm_ready,
    input  logic                   Cmd_valid,
    input  logic                   Cmd_rd,
    input  logic [6:0]             Cmd_addr,
    input  logic [15:0]            Cmd_data,
    output logic                   Cmd_ready,
    output logic                   Ac97_sync,
    output logic                   Ac97_sdata,
    output logic                   Frame_ce,
    output logic                   Underrun
);

    import ac97_pkg::*;

    logic                    bit_tick;
    logic                    frame_start;
    logic [7:0]              bit_cnt_q, bit_cnt_d;
    logic [C_FRAME_BITS-1:0] shift_q, shift_d;
    logic                    sync_q, sync_d;
    logic                    pcm_ready_q, pcm_ready_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    frame_ce_q, frame_ce_d;
    logic                    underrun_q, underrun_d;

    logic                    cmd_take;
    logic                    cmd_rd;
    logic [6:0]              cmd_addr;
    logic [15:0]             cmd_data;
    logic                    pcm_unused;

    ac97_bitclk_sync u_bitclk_sync (
        .Sys_clk     (Sys_clk),
        .Ac97_rst_n  (Ac97_rst_n),
        .Ac97_bitclk (Ac97_bitclk),
        .Bit_tick    (bit_tick)
    );

`ifdef AC97_CMD_EN
    assign cmd_take = Cmd_valid;
    assign cmd_rd   = Cmd_rd;
    assign cmd_addr = Cmd_addr;
    assign cmd_data = Cmd_data;
`else
    logic cmd_unused;
    assign cmd_unused = ^{Cmd_valid, Cmd_rd, Cmd_addr, Cmd_data};
    assign cmd_take   = 1'b0;
    assign cmd_rd     = 1'b0;
    assign cmd_addr   = '0;
    assign cmd_data   = '0;
`endif

    assign pcm_unused  = ^{Pcm_l[C_PCM_WIDTH-C_SLOT_BITS-1:0], Pcm_r[C_PCM_WIDTH-C_SLOT_BITS-1:0]};
    assign frame_start = bit_tick && (bit_cnt_q == 8'hFF);

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sync_d      = sync_q;
        pcm_ready_d = 1'b0;
        cmd_ready_d = 1'b0;
        frame_ce_d  = 1'b0;
        underrun_d  = 1'b0;
        if (bit_tick) begin
            bit_cnt_d = bit_cnt_q + 8'd1;
            sync_d    = (bit_cnt_d < 8'(C_SYNC_BITS));
            if (frame_start) begin
                shift_d = build_frame(Pcm_valid,
                                      Pcm_l[C_PCM_WIDTH-1 -: C_SLOT_BITS],
                                      Pcm_r[C_PCM_WIDTH-1 -: C_SLOT_BITS],
                                      cmd_take, cmd_rd, cmd_addr, cmd_data);
                pcm_ready_d = Pcm_valid;
                cmd_ready_d = cmd_take;
                frame_ce_d  = 1'b1;
                underrun_d  = ~Pcm_valid;
            end else begin
                shift_d = {shift_q[C_FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    // Counter parks at 255 so the first tick after reset opens a fresh frame.
    always_ff @(posedge Sys_clk) begin
        if (!Ac97_rst_n) begin
            bit_cnt_q   <= 8'hFF;
            shift_q     <= '0;
            sync_q      <= 1'b0;
            pcm_ready_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            frame_ce_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            pcm_ready_q <= pcm_ready_d;
            cmd_ready_q <= cmd_ready_d;
            frame_ce_q  <= frame_ce_d;
            underrun_q  <= underrun_d;
        end
    end

    assign Ac97_sync  = sync_q;
    assign Ac97_sdata = shift_q[C_FRAME_BITS-1];
    assign Pcm_ready  = pcm_ready_q;
    assign Cmd_ready  = cmd_ready_q;
    assign Frame_ce   = frame_ce_q;
    assign Underrun   = underrun_q;

endmodule

// File: tb/tb_ac97_frame_out.sv
// tb/tb_ac97_frame_out.sv - table-driven bench for ac97_frame_out
module tb_ac97_frame_out;

`ifdef AC97_CMD_EN
    localparam bit CMD_EN = 1'b1;
`else
    localparam bit CMD_EN = 1'b0;
`endif

    logic        Sys_clk = 1'b0;
    logic        Ac97_rst_n = 1'b0;
    logic        Ac97_bitclk = 1'b0;
    logic [31:0] Pcm_l = '0, Pcm_r = '0;
    logic        Pcm_valid = 1'b0;
    logic        Pcm_ready;
    logic        Cmd_valid = 1'b0, Cmd_rd = 1'b0;
    logic [6:0]  Cmd_addr = '0;
    logic [15:0] Cmd_data = '0;
    logic        Cmd_ready, Ac97_sync, Ac97_sdata, Frame_ce, Underrun;

    ac97_frame_out dut (
        .Sys_clk(Sys_clk), .Ac97_rst_n(Ac97_rst_n), .Ac97_bitclk(Ac97_bitclk),
        .Pcm_l(Pcm_l), .Pcm_r(Pcm_r), .Pcm_valid(Pcm_valid), .Pcm_ready(Pcm_ready),
        .Cmd_valid(Cmd_valid), .Cmd_rd(Cmd_rd), .Cmd_addr(Cmd_addr), .Cmd_data(Cmd_data),
        .Cmd_ready(Cmd_ready), .Ac97_sync(Ac97_sync), .Ac97_sdata(Ac97_sdata),
        .Frame_ce(Frame_ce), .Underrun(Underrun)
    );

    bit bclk_run = 1'b1;
    always #5 Sys_clk = ~Sys_clk;
    initial begin
        #2;
        forever begin
            #40;
            if (bclk_run) Ac97_bitclk = ~Ac97_bitclk;
        end
    end

    typedef struct {
        logic        pv;
        logic [31:0] l, r;
        logic        cv, rd;
        logic [6:0]  addr;
        logic [15:0] data;
        logic [15:0] tag;
        logic [19:0] s1, s2, s3, s4;
        logic        pr, cr, ur;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0, n_fail = 0;
    int   cnt_pr = 0, cnt_cr = 0, cnt_ur = 0, cnt_ce = 0;
    int   since = 100;
    bit   lat_en = 1'b0;
    logic prev_sync = 1'b0, prev_sdata = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge Ac97_bitclk) since = 0;
    always @(posedge Sys_clk) since++;

    // Strobe counters and BIT_CLK-to-pin latency: every pin change must land on the 3rd Sys_clk edge.
    always @(negedge Sys_clk) begin
        if (Pcm_ready) cnt_pr++;
        if (Cmd_ready) cnt_cr++;
        if (Underrun)  cnt_ur++;
        if (Frame_ce)  cnt_ce++;
        if (lat_en && (Ac97_sync !== prev_sync || Ac97_sdata !== prev_sdata)) begin
            n_vec++;
            if (since != 3) begin
                n_fail++;
                $display("FAIL latency: got %0d cycles, expected 3", since);
            end
        end
        prev_sync  = Ac97_sync;
        prev_sdata = Ac97_sdata;
    end

    task automatic zero_counts();
        cnt_pr = 0; cnt_cr = 0; cnt_ur = 0; cnt_ce = 0;
    endtask

    task automatic set_inputs(input vec_t v);
        Pcm_valid = v.pv; Pcm_l = v.l; Pcm_r = v.r;
        Cmd_valid = v.cv; Cmd_rd = v.rd; Cmd_addr = v.addr; Cmd_data = v.data;
    endtask

    task automatic wait_ce(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge Sys_clk);
            if (Frame_ce) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL frame_ce_timeout: got no Frame_ce, expected one within 3000 cycles");
        end
    endtask

    task automatic check_ce(input vec_t v, input int idx);
        chk($sformatf("v%0d pcm_ready", idx), 256'(Pcm_ready), 256'(v.pr));
        chk($sformatf("v%0d cmd_ready", idx), 256'(Cmd_ready), 256'(v.cr));
        chk($sformatf("v%0d underrun",  idx), 256'(Underrun),  256'(v.ur));
        chk($sformatf("v%0d sync_at_ce", idx), 256'(Ac97_sync), 256'(1'b1));
        #1 zero_counts();
    endtask

    // Codec view: sample SYNC/SDATA on each BIT_CLK falling edge.
    task automatic check_frame(input vec_t v, input int idx);
        logic [255:0] frm, syn;
        for (int b = 0; b < 256; b++) begin
            @(negedge Ac97_bitclk);
            frm[255-b] = Ac97_sdata;
            syn[255-b] = Ac97_sync;
        end
        chk($sformatf("v%0d tag",   idx), 256'(frm[255:240]), 256'(v.tag));
        chk($sformatf("v%0d slot1", idx), 256'(frm[239:220]), 256'(v.s1));
        chk($sformatf("v%0d slot2", idx), 256'(frm[219:200]), 256'(v.s2));
        chk($sformatf("v%0d slot3", idx), 256'(frm[199:180]), 256'(v.s3));
        chk($sformatf("v%0d slot4", idx), 256'(frm[179:160]), 256'(v.s4));
        chk($sformatf("v%0d slots5_12", idx), 256'(frm[159:0]), 256'(0));
        chk($sformatf("v%0d sync_shape", idx), syn, {16'hFFFF, 240'(0)});
        chk($sformatf("v%0d extra_strobes", idx), 256'(cnt_pr + cnt_cr + cnt_ur + cnt_ce), 256'(0));
    endtask

    initial begin
        bit ok;
        logic hold_sync, hold_sdata;

        vecs[0] = '{1'b1, 32'hABCDE000, 32'h12345000, 1'b0, 1'b0, 7'h00, 16'h0000,
                    16'h9800, 20'h0, 20'h0, 20'hABCDE, 20'h12345, 1'b1, 1'b0, 1'b0};
        vecs[1] = vecs[0];
        vecs[2] = '{1'b0, 32'hABCDE000, 32'h12345000, 1'b0, 1'b0, 7'h00, 16'h0000,
                    16'h0000, 20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'hABCDE000, 32'h12345000, 1'b1, 1'b0, 7'h02, 16'h0808,
                    CMD_EN ? 16'hF800 : 16'h9800, CMD_EN ? 20'h02000 : 20'h0,
                    CMD_EN ? 20'h08080 : 20'h0, 20'hABCDE, 20'h12345, 1'b1, CMD_EN, 1'b0};
        vecs[4] = '{1'b1, 32'h80001FFF, 32'h00000FFF, 1'b1, 1'b1, 7'h26, 16'hFFFF,
                    CMD_EN ? 16'hD800 : 16'h9800, CMD_EN ? 20'hA6000 : 20'h0,
                    20'h0, 20'h80001, 20'h00000, 1'b1, CMD_EN, 1'b0};
        vecs[5] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 7'h26, 16'h0000,
                    CMD_EN ? 16'hC000 : 16'h0000, CMD_EN ? 20'hA6000 : 20'h0,
                    20'h0, 20'h0, 20'h0, 1'b0, CMD_EN, 1'b1};
        vecs[6] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 7'h7F, 16'hFFFF,
                    CMD_EN ? 16'hE000 : 16'h0000, CMD_EN ? 20'h7F000 : 20'h0,
                    CMD_EN ? 20'hFFFF0 : 20'h0, 20'h0, 20'h0, 1'b0, CMD_EN, 1'b1};
        vecs[7] = '{1'b1, 32'hFFFFF000, 32'h00001000, 1'b0, 1'b0, 7'h00, 16'h0000,
                    16'h9800, 20'h0, 20'h0, 20'hFFFFF, 20'h00001, 1'b1, 1'b0, 1'b0};

        repeat (20) @(negedge Sys_clk);
        chk("rst sync",      256'(Ac97_sync),  256'(0));
        chk("rst sdata",     256'(Ac97_sdata), 256'(0));
        chk("rst pcm_ready", 256'(Pcm_ready),  256'(0));
        chk("rst cmd_ready", 256'(Cmd_ready),  256'(0));
        chk("rst frame_ce",  256'(Frame_ce),   256'(0));
        chk("rst underrun",  256'(Underrun),   256'(0));

        set_inputs(vecs[0]);
        Ac97_rst_n = 1'b1;
        lat_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_inputs(vecs[i]);
            wait_ce(ok);
            if (ok) begin
                check_ce(vecs[i], i);
                check_frame(vecs[i], i);
            end
        end

        // Reset at bit 100, then the very next BIT_CLK edge must open a new frame.
        set_inputs(vecs[0]);
        wait_ce(ok);
        if (ok) begin
            for (int b = 0; b < 100; b++) @(negedge Ac97_bitclk);
            @(negedge Sys_clk);
            lat_en = 1'b0;
            Ac97_rst_n = 1'b0;
            @(negedge Sys_clk);
            chk("midrst sync",      256'(Ac97_sync),  256'(0));
            chk("midrst sdata",     256'(Ac97_sdata), 256'(0));
            chk("midrst pcm_ready", 256'(Pcm_ready),  256'(0));
            chk("midrst frame_ce",  256'(Frame_ce),   256'(0));
            chk("midrst underrun",  256'(Underrun),   256'(0));
            Ac97_rst_n = 1'b1;
            @(posedge Ac97_bitclk);
            repeat (2) @(posedge Sys_clk);
            @(negedge Sys_clk);
            chk("midrst sync_cycle2", 256'(Ac97_sync), 256'(0));
            chk("midrst ce_cycle2",   256'(Frame_ce),  256'(0));
            @(posedge Sys_clk);
            @(negedge Sys_clk);
            chk("midrst ce_cycle3", 256'(Frame_ce), 256'(1));
            check_ce(vecs[0], 100);
            lat_en = 1'b1;
            check_frame(vecs[0], 100);
        end

        // BIT_CLK stops mid-frame: pins hold and no strobes fire.
        wait_ce(ok);
        if (ok) begin
            for (int b = 0; b < 20; b++) @(negedge Ac97_bitclk);
            bclk_run = 1'b0;
            repeat (10) @(negedge Sys_clk);
            hold_sync  = Ac97_sync;
            hold_sdata = Ac97_sdata;
            #1 zero_counts();
            repeat (300) @(negedge Sys_clk);
            chk("stop sync_hold",  256'(Ac97_sync),  256'(hold_sync));
            chk("stop sdata_hold", 256'(Ac97_sdata), 256'(hold_sdata));
            chk("stop strobes", 256'(cnt_pr + cnt_cr + cnt_ur + cnt_ce), 256'(0));
            bclk_run = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
